// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Result is computed at issue and committed after a fixed latency.
module mdu_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             istart,
  input  logic [2:0]       iop,
  input  logic [WIDTH-1:0] iA1,
  input  logic [WIDTH-1:0] iA2,
  input  logic             iflush,
  output logic             obusy,
  output logic             ostall,
  output logic [WIDTH-1:0] ohi,
  output logic [WIDTH-1:0] olo
);

  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_phi;
  logic [WIDTH-1:0] r_plo;
  logic             r_pwr;

  logic             w_accept;
  logic             w_arith;
  logic             w_mthi;
  logic             w_mtlo;
  logic             w_last;
  logic             w_commit;

  logic signed [2*WIDTH-1:0] w_sa;
  logic signed [2*WIDTH-1:0] w_sb;
  logic signed [2*WIDTH-1:0] w_smul;
  logic        [2*WIDTH-1:0] w_umul;
  logic signed [WIDTH-1:0]   w_sdvd;
  logic signed [WIDTH-1:0]   w_sdvs;
  logic signed [WIDTH-1:0]   w_sq;
  logic signed [WIDTH-1:0]   w_sr;
  logic        [WIDTH-1:0]   w_udvs;
  logic        [WIDTH-1:0]   w_uq;
  logic        [WIDTH-1:0]   w_ur;
  logic                      w_dz;
  logic                      w_ovf;
  logic        [WIDTH-1:0]   w_rhi;
  logic        [WIDTH-1:0]   w_rlo;
  logic                      w_rwr;

  assign w_sa   = {{WIDTH{iA1[WIDTH-1]}}, iA1};
  assign w_sb   = {{WIDTH{iA2[WIDTH-1]}}, iA2};
  assign w_smul = w_sa * w_sb;
  assign w_umul = {{WIDTH{1'b0}}, iA1} * {{WIDTH{1'b0}}, iA2};

  assign w_dz   = ~|iA2;
  assign w_ovf  = (iA1 == {1'b1, {(WIDTH-1){1'b0}}}) & (&iA2);
  // MIN/-1 divides by +1 instead: same quotient (MIN) and remainder (0).
  assign w_sdvd = iA1;
  assign w_sdvs = (w_dz | w_ovf) ? WIDTH'(1) : iA2;
  assign w_sq   = w_sdvd / w_sdvs;
  assign w_sr   = w_sdvd % w_sdvs;
  assign w_udvs = w_dz ? WIDTH'(1) : iA2;
  assign w_uq   = iA1 / w_udvs;
  assign w_ur   = iA1 % w_udvs;

  always_comb begin
    w_rhi = '0;
    w_rlo = '0;
    w_rwr = 1'b1;
    unique case (iop[1:0])
      2'd0: {w_rhi, w_rlo} = w_smul;
      2'd1: {w_rhi, w_rlo} = w_umul;
      2'd2: begin
        w_rwr = ~w_dz;
        w_rlo = w_sq;
        w_rhi = w_sr;
      end
      2'd3: begin
        w_rwr = ~w_dz;
        w_rlo = w_uq;
        w_rhi = w_ur;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_arith) w_next = S_BUSY;
      S_BUSY: if (iflush || w_last) w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept = istart & ~iflush & (r_state == S_IDLE);
    w_arith  = w_accept & ~iop[2];
    w_mthi   = w_accept & (iop == 3'd4);
    w_mtlo   = w_accept & (iop == 3'd5);
    w_last   = (r_cnt == CW'(1));
    w_commit = (r_state == S_BUSY) & ~iflush & w_last;
    obusy    = (r_state == S_BUSY);
    ostall   = obusy | (istart & ~iop[2]);
    ohi      = r_hi;
    olo      = r_lo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_arith) begin
      r_cnt <= iop[1] ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_phi <= '0;
      r_plo <= '0;
      r_pwr <= 1'b0;
    end else begin
      if (w_arith) begin
        r_phi <= w_rhi;
        r_plo <= w_rlo;
        r_pwr <= w_rwr;
      end
      if (w_mthi) r_hi <= iA1;
      if (w_mtlo) r_lo <= iA1;
      if (w_commit && r_pwr) begin
        r_hi <= r_phi;
        r_lo <= r_plo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: stimulus pushes expected HI/LO and busy
// length, a negedge monitor pops and compares whenever obusy falls.
module tb_mdu_iter;

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         istart;
  logic [2:0]   iop;
  logic [W-1:0] iA1;
  logic [W-1:0] iA2;
  logic         iflush;
  logic         obusy;
  logic         ostall;
  logic [W-1:0] ohi;
  logic [W-1:0] olo;

  mdu_iter #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .istart(istart), .iop(iop),
    .iA1(iA1), .iA2(iA2), .iflush(iflush),
    .obusy(obusy), .ostall(ostall), .ohi(ohi), .olo(olo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } item_t;

  item_t        sb[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from the architectural definition.
  task automatic ref_op(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic wr,
                        output logic [W-1:0] h, output logic [W-1:0] l);
    int          sa, sb_;
    longint      sp;
    logic [63:0] up;
    sa = a; sb_ = b; wr = 1'b1; h = '0; l = '0;
    case (op)
      3'd0: begin sp = longint'(sa) * longint'(sb_); {h, l} = sp; end
      3'd1: begin up = 64'(a) * 64'(b); {h, l} = up; end
      3'd2: begin
        if (b == 0) wr = 1'b0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = a; h = '0;
        end else begin
          l = sa / sb_; h = sa % sb_;
        end
      end
      3'd3: begin
        if (b == 0) wr = 1'b0;
        else begin l = a / b; h = a % b; end
      end
      default: wr = 1'b0;
    endcase
  endtask

  int  busy_cnt = 0;
  bit  prev_busy = 1'b0;
  item_t it;

  always @(negedge clk) begin
    if (reset) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (obusy) busy_cnt++;
      else if (prev_busy) begin
        if (sb.size() == 0) chk("unexpected_done", 64'(busy_cnt), 64'(0));
        else begin
          it = sb.pop_front();
          chk("busy_len", 64'(busy_cnt), 64'(it.lat));
          chk("hi", 64'(ohi), 64'(it.hi));
          chk("lo", 64'(olo), 64'(it.lo));
        end
        busy_cnt = 0;
      end
      prev_busy = obusy;
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int flush_at,
                       input int replay_at);
    logic         wr;
    logic [W-1:0] h, l;
    int           lat;
    bit           done;
    @(posedge clk); #1;
    istart = 1'b1; iop = op; iA1 = a; iA2 = b;
    #1 chk("stall_issue", 64'(ostall), 64'(op <= 3'd3));
    @(posedge clk); #1;
    istart = 1'b0;
    if (op <= 3'd3) begin
      ref_op(op, a, b, wr, h, l);
      lat = op[1] ? DL : ML;
      if (flush_at > 0) begin
        sb.push_back('{m_hi, m_lo, flush_at});
        for (int k = 1; k < flush_at; k++) begin
          @(posedge clk); #1;
        end
        iflush = 1'b1;
        @(posedge clk); #1;
        iflush = 1'b0;
        chk("busy_after_flush", 64'(obusy), 64'(0));
      end else begin
        if (wr) begin m_hi = h; m_lo = l; end
        sb.push_back('{m_hi, m_lo, lat});
        done = 1'b0;
        for (int k = 1; k <= lat + 4; k++) begin
          if (!obusy) begin done = 1'b1; break; end
          if (k == replay_at) begin
            istart = 1'b1; iop = 3'd0; iA1 = 32'd6; iA2 = 32'd7;
          end
          #1 chk("stall_busy", 64'(ostall), 64'(1));
          @(posedge clk); #1;
          istart = 1'b0;
        end
        if (!done) chk("busy_timeout", 64'(obusy), 64'(0));
      end
    end else begin
      if (op == 3'd4) m_hi = a;
      if (op == 3'd5) m_lo = a;
      chk("mt_hi", 64'(ohi), 64'(m_hi));
      chk("mt_lo", 64'(olo), 64'(m_lo));
      chk("mt_busy", 64'(obusy), 64'(0));
    end
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [2:0] op;
    int         fa, ra;
    reset = 1'b1; istart = 1'b0; iop = '0; iA1 = '0; iA2 = '0; iflush = 1'b0;
    #1;
    chk("rst_busy", 64'(obusy), 64'(0));
    chk("rst_stall", 64'(ostall), 64'(0));
    chk("rst_hi", 64'(ohi), 64'(0));
    chk("rst_lo", 64'(olo), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    do_op(3'd0, 32'hFFFF_FFFD, 32'd5, 0, 0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_op(3'd3, 32'd7, 32'd2, 0, 0);
    do_op(3'd4, 32'h1234_5678, 32'd0, 0, 0);
    do_op(3'd3, 32'd99, 32'd0, 0, 0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2);
    do_op(3'd0, 32'd6, 32'd7, 3, 0);
    do_op(3'd5, 32'hCAFE_F00D, 32'd0, 0, 0);
    do_op(3'd6, 32'h1111_1111, 32'd0, 0, 0);

    // flush blocks a same-cycle start and MT write
    @(posedge clk); #1;
    istart = 1'b1; iop = 3'd0; iA1 = 32'd3; iA2 = 32'd4; iflush = 1'b1;
    @(posedge clk); #1;
    iop = 3'd4;
    @(posedge clk); #1;
    istart = 1'b0; iflush = 1'b0;
    chk("flush_start_busy", 64'(obusy), 64'(0));
    chk("flush_start_hi", 64'(ohi), 64'(m_hi));
    chk("flush_start_lo", 64'(olo), 64'(m_lo));

    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      fa = 0; ra = 0;
      if (op <= 3'd3 && $urandom_range(0, 5) == 0)
        fa = $urandom_range(1, op[1] ? DL : ML);
      else if (op <= 3'd3 && $urandom_range(0, 3) == 0)
        ra = $urandom_range(1, 3);
      do_op(op, rnd_val(), rnd_val(), fa, ra);
    end

    // asynchronous reset in the middle of a divide
    @(posedge clk); #1;
    istart = 1'b1; iop = 3'd2; iA1 = 32'd100; iA2 = 32'd7;
    @(posedge clk); #1;
    istart = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    sb.delete();
    m_hi = '0; m_lo = '0;
    #1;
    chk("arst_busy", 64'(obusy), 64'(0));
    chk("arst_hi", 64'(ohi), 64'(0));
    chk("arst_lo", 64'(olo), 64'(0));
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    do_op(3'd3, 32'd7, 32'd2, 0, 0);

    repeat (3) @(posedge clk);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
